// File: rtl/emu_osc_dt_gen.sv
// Emulated-oscillator timestep requester: asks the arbiter for the time left to the next modelled clock edge
// and toggles the modelled clock when the grant reaches it. Optional edge counter: EMU_OSC_EDGE_CNT_EN.
module emu_osc_dt_gen #(
  parameter int                      width  = 32,
  parameter logic signed [width-1:0] dt_max = {1'b0, {(width-1){1'b1}}}
) (
  input  logic                    emu_clk,
  input  logic                    emu_rst,
  input  logic                    en,
  input  logic signed [width-1:0] t_lo,
  input  logic signed [width-1:0] t_hi,
  input  logic signed [width-1:0] emu_dt,
  output logic signed [width-1:0] dt_req,
`ifdef EMU_OSC_EDGE_CNT_EN
  output logic [31:0]             edge_cnt,
`endif
  output logic                    clk_val,
  output logic                    cke_rise,
  output logic                    cke_fall,
  output logic                    overshoot
);

  typedef enum logic {LOW = 1'b0, HIGH = 1'b1} state_t;

  localparam logic signed [width-1:0] ONE = {{(width-1){1'b0}}, 1'b1};

  state_t                  state_q, state_d;
  logic signed [width-1:0] t_rem_q, t_rem_d;
  logic                    ovs_q, ovs_d;
  logic                    rise_q, rise_d;
  logic                    fall_q, fall_d;

  // Non-positive durations become 1 so the emulator can never stall on a zero timestep.
  function automatic logic signed [width-1:0] clamp(input logic signed [width-1:0] v);
    return (v > 0) ? v : ONE;
  endfunction

  always_comb begin
    state_d = state_q;
    t_rem_d = t_rem_q;
    ovs_d   = ovs_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (en && emu_dt > 0) begin
      if (emu_dt < t_rem_q) begin
        t_rem_d = t_rem_q - emu_dt;
      end else begin
        // Excess beyond the edge is dropped; the new phase starts full length.
        if (emu_dt > t_rem_q) ovs_d = 1'b1;
        if (state_q == LOW) begin
          state_d = HIGH;
          t_rem_d = clamp(t_hi);
          rise_d  = 1'b1;
        end else begin
          state_d = LOW;
          t_rem_d = clamp(t_lo);
          fall_d  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge emu_clk) begin
    if (emu_rst) begin
      state_q <= LOW;
      t_rem_q <= clamp(t_lo);
      ovs_q   <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      t_rem_q <= t_rem_d;
      ovs_q   <= ovs_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

`ifdef EMU_OSC_EDGE_CNT_EN
  always_ff @(posedge emu_clk) begin
    if (emu_rst)              edge_cnt <= '0;
    else if (rise_d | fall_d) edge_cnt <= edge_cnt + 32'd1;
  end
`endif

  assign dt_req    = en ? t_rem_q : dt_max;
  assign clk_val   = (state_q == HIGH);
  assign cke_rise  = rise_q;
  assign cke_fall  = fall_q;
  assign overshoot = ovs_q;

endmodule

// File: tb/tb_emu_osc_dt_gen.sv
// Bench for emu_osc_dt_gen: directed scenarios plus random grants, checked against an absolute-time model
// (current time vs. time of next edge).
module tb_emu_osc_dt_gen;

  localparam longint DT_MAX = 64'sd2147483647;

  logic               emu_clk = 1'b0;
  logic               emu_rst = 1'b1;
  logic               en = 1'b0;
  logic signed [31:0] t_lo = 32'sd5;
  logic signed [31:0] t_hi = 32'sd3;
  logic signed [31:0] emu_dt = '0;
  logic signed [31:0] dt_req;
  logic               clk_val, cke_rise, cke_fall, overshoot;
`ifdef EMU_OSC_EDGE_CNT_EN
  logic [31:0]        edge_cnt;
  int unsigned        m_cnt;
`endif

  emu_osc_dt_gen dut (
    .emu_clk  (emu_clk),
    .emu_rst  (emu_rst),
    .en       (en),
    .t_lo     (t_lo),
    .t_hi     (t_hi),
    .emu_dt   (emu_dt),
    .dt_req   (dt_req),
`ifdef EMU_OSC_EDGE_CNT_EN
    .edge_cnt (edge_cnt),
`endif
    .clk_val  (clk_val),
    .cke_rise (cke_rise),
    .cke_fall (cke_fall),
    .overshoot(overshoot)
  );

  always #5 emu_clk = ~emu_clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model in absolute time: now_t advances by grants, edge_t is when the level flips.
  longint now_t = 0, edge_t = 1;
  bit     m_lvl = 0, m_ovs = 0, m_rise = 0, m_fall = 0;

  function automatic longint cl(input longint v);
    return (v <= 0) ? 64'sd1 : v;
  endfunction

  function automatic longint rem();
    return edge_t - now_t;
  endfunction

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step(input bit rst, input bit e, input longint dt);
    m_rise = 0;
    m_fall = 0;
    if (rst) begin
      now_t = 0; edge_t = cl(t_lo); m_lvl = 0; m_ovs = 0;
`ifdef EMU_OSC_EDGE_CNT_EN
      m_cnt = 0;
`endif
    end else if (e && dt > 0) begin
      if (now_t + dt >= edge_t) begin
        if (now_t + dt > edge_t) m_ovs = 1;
        now_t  = edge_t;
        m_lvl  = ~m_lvl;
        edge_t = now_t + cl(m_lvl ? longint'(t_hi) : longint'(t_lo));
        m_rise = m_lvl;
        m_fall = ~m_lvl;
`ifdef EMU_OSC_EDGE_CNT_EN
        m_cnt  = m_cnt + 1;
`endif
      end else begin
        now_t = now_t + dt;
      end
    end
  endtask

  // One emulator cycle: drive, check the combinational request, clock, check registered outputs.
  task automatic cyc(input bit rst, input bit e, input longint dt);
    emu_rst = rst;
    en      = e;
    emu_dt  = 32'(dt);
    #1;
    if (!rst) chk("dt_req", longint'(dt_req), e ? rem() : DT_MAX);
    @(posedge emu_clk);
    model_step(rst, e, dt);
    #1;
    chk("clk_val",   longint'(clk_val),   longint'(m_lvl));
    chk("cke_rise",  longint'(cke_rise),  longint'(m_rise));
    chk("cke_fall",  longint'(cke_fall),  longint'(m_fall));
    chk("overshoot", longint'(overshoot), longint'(m_ovs));
`ifdef EMU_OSC_EDGE_CNT_EN
    chk("edge_cnt",  longint'(edge_cnt),  longint'(m_cnt));
`endif
  endtask

  task automatic grant_req(input int n);
    repeat (n) cyc(0, 1, rem());
  endtask

  initial begin
    // 5/3 oscillator granted exactly its request each cycle
    t_lo = 5; t_hi = 3;
    cyc(1, 1, 0);
    chk("reset_req", longint'(dt_req), 64'sd5);
    grant_req(6);

    // external minimum of 4 against a 10-unit low phase: 10, 6, 2, then edge
    t_lo = 10; t_hi = 3;
    cyc(1, 1, 0);
    cyc(0, 1, 4);
    cyc(0, 1, 4);
    chk("rem_after_8", longint'(dt_req), 64'sd2);
    cyc(0, 1, 2);
    chk("rise_at_2", longint'(clk_val), 64'sd1);

    // overshoot: remaining 2, granted 7; flag sticks until reset
    t_lo = 2; t_hi = 4;
    cyc(1, 1, 0);
    cyc(0, 1, 7);
    chk("ovs_rem_hi", longint'(dt_req), 64'sd4);
    grant_req(3);
    cyc(0, 1, 0);
    cyc(0, 1, -5);
    cyc(1, 1, 0);
    chk("ovs_cleared", longint'(overshoot), 64'sd0);

    // enable gating mid-phase with 6 remaining
    t_lo = 10; t_hi = 3;
    cyc(1, 1, 0);
    cyc(0, 1, 4);
    for (int i = 0; i < 5; i++) cyc(0, 0, longint'($urandom_range(0, 20)));
    cyc(0, 1, 0);
    chk("resume_req", longint'(dt_req), 64'sd6);

    // non-positive durations clamp to 1: toggles every cycle with dt=1
    t_lo = -3; t_hi = 0;
    cyc(1, 1, 0);
    for (int i = 0; i < 6; i++) cyc(0, 1, 1);

`ifdef EMU_OSC_EDGE_CNT_EN
    chk("cnt_6", longint'(edge_cnt), 64'sd6);
    force dut.edge_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.edge_cnt;
    m_cnt = 32'hFFFF_FFFF;
    cyc(0, 1, 1);
    chk("cnt_wrap", longint'(edge_cnt), 64'sd0);
    cyc(0, 1, 1);
    cyc(1, 1, 0);
    chk("cnt_rst", longint'(edge_cnt), 64'sd0);
`endif

    // random grants, durations, enables and occasional resets
    for (int i = 0; i < 300; i++) begin
      longint r;
      t_lo = 32'($urandom_range(0, 10)) - 32'sd2;
      t_hi = 32'($urandom_range(0, 10)) - 32'sd2;
      r = rem();
      if ($urandom_range(0, 39) == 0)      cyc(1, 1, 0);
      else if ($urandom_range(0, 7) == 0)  cyc(0, 0, longint'($urandom_range(0, 12)));
      else                                 cyc(0, 1, longint'($urandom_range(0, 32'(r) + 3)) - 2);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
